mem_port_master: RTL
====================

Name: mem_port_master

Overview:
- Requester-side controller for one port of the team's dual-port byte-enabled URAM buffer.
- Accepts read/write requests on a valid/ready interface and drives the memory port (en, per-byte wen, addr, din).
- Tracks the fixed read latency of the memory and returns read data in order on a valid/ready response channel.
- Uses a credit-limited response FIFO, so downstream backpressure never loses data.

Parameters:
- BYTES_PER_LINE, 4, bytes per memory line
- ADDR_WIDTH, 13, memory address width
- LINE_SIZE, 8*BYTES_PER_LINE, line width in bits
- MEM_LATENCY, 1, cycles from mem_en (read) to valid mem_dout; legal values 1..4
- RSP_DEPTH, 4, response FIFO entries; must be power of 2 and >= MEM_LATENCY+1

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_wr  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  line address
- req_wstrb  in  BYTES_PER_LINE  byte enables (writes only)
- req_wdata  in  LINE_SIZE  write data
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer ready
- rsp_data  out  LINE_SIZE  read data
- mem_en  out  1  memory port enable
- mem_wen  out  BYTES_PER_LINE  memory byte write enables
- mem_addr  out  ADDR_WIDTH  memory address
- mem_din  out  LINE_SIZE  memory write data
- mem_dout  in  LINE_SIZE  memory read data (registered in memory)
- rd_inflight  out  $clog2(RSP_DEPTH)+1  reads issued but not yet popped

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: clk and rstn.
  - Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rd_inflight=0, latency pipe cleared, FIFO pointers 0.
  - req_ready rises the first cycle after rstn=1.
- Credits:
  - credits_used = reads in latency pipe + FIFO occupancy.
  - req_ready = (credits_used < RSP_DEPTH), registered-free combinational from state.
  - Applies to both reads and writes, which keeps strict program order simple.
- Issue (combinational from the accepted request, same cycle):
  - Common: mem_addr=req_addr, mem_din=req_wdata.
  - Accepted read: mem_en=1, mem_wen=0.
  - Accepted write with nonzero strobe: mem_en=1, mem_wen=req_wstrb.
  - Write with req_wstrb==0: accepted and dropped, mem_en=0. The memory would otherwise treat it as a read and clobber its output.
  - No acceptance: mem_en=0, mem_wen=0.
- Latency pipe:
  - MEM_LATENCY-stage valid shift register, loaded with 1 on an accepted read.
  - When a tail bit is set, mem_dout is written to the FIFO at that edge.
  - Accept at cycle T gives rsp_valid no earlier than cycle T+MEM_LATENCY+1.
  - mem_dout is sampled only at the tail cycle; the memory holds output across writes, so no other sampling is allowed.
- Response FIFO:
  - First-word-fall-through: rsp_valid = !empty, rsp_data = head.
  - Pop on rsp_valid&rsp_ready.
  - Simultaneous push and pop is legal at any occupancy, including full.
  - Overflow is impossible by credit. An assertion in simulation checks this.
- Ordering:
  - Responses are returned in issue order.
  - A read issued the cycle after a write to the same address returns the new data, because the memory write is registered.
- rd_inflight:
  - Increments on an accepted read, decrements on a pop.
  - Both in the same cycle leaves it unchanged.
- Reset mid-operation: in-flight reads and FIFO contents are discarded, with no spurious rsp_valid afterwards.

Optional Feature:
- Macro: MEM_PORT_MASTER_STATS_EN.
- When defined, adds three 32-bit saturating counters as outputs, all cleared by reset:
  - stat_rd (accepted reads)
  - stat_wr (accepted writes with nonzero strobe)
  - stat_stall (cycles with req_valid=1, req_ready=0)
- Counters saturate at 0xFFFFFFFF.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Write then read:
  - Stimulus: write addr 0x010, wstrb 0xF, data 0xDEADBEEF; next cycle read 0x010; rsp_ready=1.
  - Required response: rsp_valid exactly 2 cycles after the read accept (MEM_LATENCY=1), rsp_data=0xDEADBEEF, rd_inflight returns to 0.
- Partial write:
  - Stimulus: write 0x11223344 to 0x020, then wstrb 0x2 with data 0x0000AA00, then read 0x020.
  - Required response: 0x1122AA44.
- Zero-strobe write:
  - Stimulus: read 0x010 issued, then wstrb=0 write to 0x030 on the next cycle.
  - Required response: mem_en=0 on the write cycle, no response for the write, read returns 0xDEADBEEF.
- Backpressure:
  - Stimulus: rsp_ready=0, issue 6 back-to-back reads of 0x000..0x005 preloaded with 0..5.
  - Required response: only 4 accepted, req_ready=0 with rd_inflight=4. Raising rsp_ready yields 0,1,2,3,4,5 in order, with no gaps at full throughput.
- Reset mid-operation:
  - Stimulus: 2 reads in flight, rstn=0 for 1 cycle.
  - Required response: rsp_valid=0, rd_inflight=0, no response afterwards; a new read of 0x010 returns 0xDEADBEEF.
- Stats (MEM_PORT_MASTER_STATS_EN):
  - Stimulus: the backpressure scenario.
  - Required response: stat_rd=6, stat_wr=0, stat_stall equals the counted stall cycles.

Source files
------------

// File: rtl/mem_port_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_master
// Brief    : Requester-side controller for one port of a byte-enabled URAM;
//            credit-limited in-order read response FIFO.
//            Optional stats counters under MEM_PORT_MASTER_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_master #(
    parameter int BYTES_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 13,
    parameter int LINE_SIZE      = 8*BYTES_PER_LINE,
    parameter int MEM_LATENCY    = 1,
    parameter int RSP_DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_wr,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [BYTES_PER_LINE-1:0]      req_wstrb,
    input  logic [LINE_SIZE-1:0]           req_wdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [LINE_SIZE-1:0]           rsp_data,
    output logic                           mem_en,
    output logic [BYTES_PER_LINE-1:0]      mem_wen,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [LINE_SIZE-1:0]           mem_din,
    input  logic [LINE_SIZE-1:0]           mem_dout,
    output logic [$clog2(RSP_DEPTH):0]     rd_inflight
`ifdef MEM_PORT_MASTER_STATS_EN
    ,
    output logic [31:0]                    stat_rd,
    output logic [31:0]                    stat_wr,
    output logic [31:0]                    stat_stall
`endif
);

    localparam int               c_ptr_w = $clog2(RSP_DEPTH);
    localparam int               c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w+1)'(RSP_DEPTH);

    logic                   r_init;
    logic [MEM_LATENCY-1:0] r_pipe;
    logic [LINE_SIZE-1:0]   r_fifo [RSP_DEPTH];
    logic [c_ptr_w-1:0]     r_wptr;
    logic [c_ptr_w-1:0]     r_rptr;
    logic [c_cnt_w-1:0]     r_count;
    logic [c_cnt_w-1:0]     r_inflight;
    logic [c_cnt_w:0]       w_credits;
    logic                   w_acc;
    logic                   w_acc_rd;
    logic                   w_acc_wr;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;

    function automatic logic [c_cnt_w:0] f_pipe_count(input logic [MEM_LATENCY-1:0] v);
        logic [c_cnt_w:0] n;
        n = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            n = n + {{c_cnt_w{1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Every request, read or write, needs a free credit so ordering stays trivial.
    assign w_credits = f_pipe_count(r_pipe) + {1'b0, r_count};
    assign req_ready = r_init & rstn & (w_credits < c_depth);

    assign w_acc    = req_valid & req_ready;
    assign w_acc_rd = w_acc & ~req_wr;
    assign w_acc_wr = w_acc & req_wr & (|req_wstrb);

    // A zero-strobe write must not reach the memory: it would look like a read.
    always_comb begin
        mem_en   = 1'b0;
        mem_wen  = '0;
        mem_addr = req_addr;
        mem_din  = req_wdata;
        if (w_acc_rd) begin
            mem_en = 1'b1;
        end else if (w_acc_wr) begin
            mem_en  = 1'b1;
            mem_wen = req_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_init <= 1'b0;
        else       r_init <= 1'b1;
    end

    generate
        if (MEM_LATENCY == 1) begin : g_pipe_single
            always_ff @(posedge clk) begin
                if (!rstn) r_pipe <= '0;
                else       r_pipe <= w_acc_rd;
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk) begin
                if (!rstn) r_pipe <= '0;
                else       r_pipe <= {r_pipe[MEM_LATENCY-2:0], w_acc_rd};
            end
        end
    endgenerate

    // mem_dout is only trusted in the tail cycle of a tracked read.
    assign w_push  = r_pipe[MEM_LATENCY-1];
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & rsp_ready;

    assign rsp_valid   = ~w_empty;
    assign rsp_data    = w_empty ? '0 : r_fifo[r_rptr];
    assign rd_inflight = r_inflight;

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= mem_dout;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case ({w_acc_rd, w_pop})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

`ifdef MEM_PORT_MASTER_STATS_EN
    logic w_stall;
    assign w_stall = req_valid & ~req_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_rd    <= '0;
            stat_wr    <= '0;
            stat_stall <= '0;
        end else begin
            if (w_acc_rd && stat_rd != 32'hFFFF_FFFF)    stat_rd    <= stat_rd + 32'd1;
            if (w_acc_wr && stat_wr != 32'hFFFF_FFFF)    stat_wr    <= stat_wr + 32'd1;
            if (w_stall && stat_stall != 32'hFFFF_FFFF)  stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(w_push && !w_pop && ({1'b0, r_count} == c_depth)));
`endif

endmodule
`default_nettype wire
